// File: rtl/mio_bus_responder.sv
// mio_bus_responder: far-side responder of the CPU MIO bus.
// Decodes each word request to the external synchronous RAM, the LED/switch
// port or a free-running cycle counter, and completes it with a single-cycle
// mio_ready pulse. RAM reads insert RAM_LAT wait cycles before completion.
module mio_bus_responder #(
    parameter int          ADDR_W   = 10,
    parameter int          RAM_LAT  = 1,
    parameter logic [31:0] BAD_DATA = 32'hDEAD_BEEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              mem_r,
    input  logic              mem_w,
    input  logic [31:0]       addr,
    input  logic [31:0]       cpu_wdata,
    output logic [31:0]       cpu_rdata,
    output logic              mio_ready,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [31:0]       ram_wdata,
    output logic              ram_we,
    input  logic [31:0]       ram_rdata,
    input  logic [15:0]       sw,
    output logic [15:0]       led
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        DONE = 2'd2
    } state_t;

    // Wait counter preload: WAIT lasts RAM_LAT cycles, the last of which
    // samples ram_rdata.
    localparam logic [3:0] WAIT_INIT = 4'(RAM_LAT - 1);

    localparam logic [31:0] IO_ADDR  = 32'hF000_0000;
    localparam logic [31:0] CNT_ADDR = 32'hF000_0004;

    state_t      state_q, state_d;
    logic [3:0]  wait_q, wait_d;
    logic [31:0] cpu_rdata_q, cpu_rdata_d;
    logic [15:0] led_q, led_d;
    logic [31:0] cnt_q, cnt_d;

    logic sel_ram;
    logic sel_io;
    logic sel_cnt;
    logic req;
    logic is_read;
    logic done_wr;

    // Address decode and request qualification; a write wins when both
    // strobes are high.
    always_comb begin
        sel_ram = (addr[31:28] == 4'h0);
        sel_io  = (addr == IO_ADDR);
        sel_cnt = (addr == CNT_ADDR);
        req     = mem_r | mem_w;
        is_read = mem_r & ~mem_w;
        done_wr = (state_q == DONE) & mem_w;
    end

    // Next state, wait counter and read-data capture.
    always_comb begin
        state_d     = state_q;
        wait_d      = wait_q;
        cpu_rdata_d = cpu_rdata_q;
        case (state_q)
            IDLE: begin
                if (req) begin
                    if (is_read && sel_ram) begin
                        state_d = WAIT;
                        wait_d  = WAIT_INIT;
                    end else begin
                        state_d = DONE;
                        if (is_read) begin
                            if (sel_io) begin
                                cpu_rdata_d = {16'h0000, sw};
                            end else if (sel_cnt) begin
                                cpu_rdata_d = cnt_q;
                            end else begin
                                cpu_rdata_d = BAD_DATA;
                            end
                        end
                    end
                end
            end
            WAIT: begin
                if (wait_q == 4'd0) begin
                    cpu_rdata_d = ram_rdata;
                    state_d     = DONE;
                end else begin
                    wait_d = wait_q - 4'd1;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Register writes commit at the end of DONE; a counter write replaces
    // that cycle's increment.
    always_comb begin
        led_d = led_q;
        cnt_d = cnt_q + 32'd1;
        if (done_wr && sel_io) begin
            led_d = cpu_wdata[15:0];
        end
        if (done_wr && sel_cnt) begin
            cnt_d = cpu_wdata;
        end
    end

    // State and datapath registers, asynchronously cleared.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            wait_q      <= 4'd0;
            cpu_rdata_q <= 32'd0;
            led_q       <= 16'd0;
            cnt_q       <= 32'd0;
        end else begin
            state_q     <= state_d;
            wait_q      <= wait_d;
            cpu_rdata_q <= cpu_rdata_d;
            led_q       <= led_d;
            cnt_q       <= cnt_d;
        end
    end

    assign cpu_rdata = cpu_rdata_q;
    assign led       = led_q;
    assign mio_ready = (state_q == DONE);
    assign ram_we    = done_wr & sel_ram;
    assign ram_addr  = addr[ADDR_W+1:2];
    assign ram_wdata = cpu_wdata;

endmodule
